// File: rtl/alu_share_arb.sv
// alu_share_arb: two-port round-robin arbiter that time-shares one
// combinational execute ALU between the EX stage (port 0) and the
// secondary branch/debug issue path (port 1).
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   rN_i_valid/rN_o_ready   request handshake per port (ready is combinational)
//   rN_i_data_rs/rt/imm/funct/alu_src/pc   request payload
//   rN_o_valid/rN_i_ack     held response handshake per port
//   rN_o_value/pc/change_pc captured ALU results
//   o_alu_*                 registered operands driven onto the ALU
//   i_alu_value/pc/change_pc ALU results, sampled during EXEC
//   o_busy                  high while an operation is executing
//   o_grant_id              owner of the most recent grant
module alu_share_arb #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned IMM_WIDTH = 16,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned FWIDTH    = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,

  input  logic                 r0_i_valid,
  output logic                 r0_o_ready,
  input  logic [DWIDTH-1:0]    r0_i_data_rs,
  input  logic [DWIDTH-1:0]    r0_i_data_rt,
  input  logic [IMM_WIDTH-1:0] r0_i_imm,
  input  logic [FWIDTH-1:0]    r0_i_funct,
  input  logic                 r0_i_alu_src,
  input  logic [PC_WIDTH-1:0]  r0_i_pc,
  output logic                 r0_o_valid,
  input  logic                 r0_i_ack,
  output logic [DWIDTH-1:0]    r0_o_value,
  output logic [PC_WIDTH-1:0]  r0_o_pc,
  output logic                 r0_o_change_pc,

  input  logic                 r1_i_valid,
  output logic                 r1_o_ready,
  input  logic [DWIDTH-1:0]    r1_i_data_rs,
  input  logic [DWIDTH-1:0]    r1_i_data_rt,
  input  logic [IMM_WIDTH-1:0] r1_i_imm,
  input  logic [FWIDTH-1:0]    r1_i_funct,
  input  logic                 r1_i_alu_src,
  input  logic [PC_WIDTH-1:0]  r1_i_pc,
  output logic                 r1_o_valid,
  input  logic                 r1_i_ack,
  output logic [DWIDTH-1:0]    r1_o_value,
  output logic [PC_WIDTH-1:0]  r1_o_pc,
  output logic                 r1_o_change_pc,

  output logic [DWIDTH-1:0]    o_alu_rs,
  output logic [DWIDTH-1:0]    o_alu_rt,
  output logic [IMM_WIDTH-1:0] o_alu_imm,
  output logic [FWIDTH-1:0]    o_alu_funct,
  output logic                 o_alu_src,
  output logic [PC_WIDTH-1:0]  o_alu_pc,
  input  logic [DWIDTH-1:0]    i_alu_value,
  input  logic [PC_WIDTH-1:0]  i_alu_pc,
  input  logic                 i_alu_change_pc,

  output logic                 o_busy,
  output logic                 o_grant_id
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   owner_q;
  logic   elig0, elig1;
  logic   win0, win1;
  logic   accept;

  // Arbitration and next-state: a slot freed by a same-cycle ack is reusable.
  always_comb begin
    elig0      = r0_i_valid & (~r0_o_valid | r0_i_ack);
    elig1      = r1_i_valid & (~r1_o_valid | r1_i_ack);
    // On a tie the port that was not granted last wins.
    win0       = elig0 & (~elig1 | last_grant_q);
    win1       = elig1 & (~elig0 | ~last_grant_q);
    r0_o_ready = (state_q == IDLE) & win0;
    r1_o_ready = (state_q == IDLE) & win1;
    accept     = r0_o_ready | r1_o_ready;
    state_d    = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant history and ALU operand registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      o_alu_rs     <= '0;
      o_alu_rt     <= '0;
      o_alu_imm    <= '0;
      o_alu_funct  <= '0;
      o_alu_src    <= 1'b0;
      o_alu_pc     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= r1_o_ready;
        last_grant_q <= r1_o_ready;
        o_alu_rs     <= r1_o_ready ? r1_i_data_rs : r0_i_data_rs;
        o_alu_rt     <= r1_o_ready ? r1_i_data_rt : r0_i_data_rt;
        o_alu_imm    <= r1_o_ready ? r1_i_imm     : r0_i_imm;
        o_alu_funct  <= r1_o_ready ? r1_i_funct   : r0_i_funct;
        o_alu_src    <= r1_o_ready ? r1_i_alu_src : r0_i_alu_src;
        o_alu_pc     <= r1_o_ready ? r1_i_pc      : r0_i_pc;
      end
    end
  end

  // Port 0 response: capture beats a coincident ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r0_o_valid     <= 1'b0;
      r0_o_value     <= '0;
      r0_o_pc        <= '0;
      r0_o_change_pc <= 1'b0;
    end else if ((state_q == EXEC) && !owner_q) begin
      r0_o_valid     <= 1'b1;
      r0_o_value     <= i_alu_value;
      r0_o_pc        <= i_alu_pc;
      r0_o_change_pc <= i_alu_change_pc;
    end else if (r0_i_ack) begin
      r0_o_valid <= 1'b0;
    end
  end

  // Port 1 response: capture beats a coincident ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r1_o_valid     <= 1'b0;
      r1_o_value     <= '0;
      r1_o_pc        <= '0;
      r1_o_change_pc <= 1'b0;
    end else if ((state_q == EXEC) && owner_q) begin
      r1_o_valid     <= 1'b1;
      r1_o_value     <= i_alu_value;
      r1_o_pc        <= i_alu_pc;
      r1_o_change_pc <= i_alu_change_pc;
    end else if (r1_i_ack) begin
      r1_o_valid <= 1'b0;
    end
  end

  assign o_busy     = (state_q == EXEC);
  assign o_grant_id = last_grant_q;

endmodule
